// File: rtl/prog_loader.sv
// prog_loader -- framed byte-stream program loader for the pipelined core.
//
// Receives MAGIC, LEN_LO, LEN_HI, 4*N payload bytes and CSUM from a byte
// source and writes the N little-endian 32-bit words into instruction
// memory starting at word address 0. The core is held in reset until the
// whole image has been written and the 8-bit additive checksum matches.
//
// Handshake: rx_ready is always 1. A byte is transferred on every cycle
// where rx_valid && rx_ready is high at the rising clock edge.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/valid     incoming byte stream
//   rx_ready          always high; the loader never stalls the source
//   imem_we           one-cycle write strobe per assembled word
//   imem_addr/wdata   write address/data, held while imem_we is low
//   core_rst_n        active-low core reset, released only on DONE
//   load_done         sticky: image loaded with a correct checksum
//   load_err          sticky: frame aborted (length, checksum or timeout)
module prog_loader #(
   parameter int          ADDR_WIDTH     = 12,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst_n,
   output logic                  load_done,
   output logic                  load_err
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN0  = 3'd1;
   localparam logic [2:0] ST_LEN1  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_CSUM  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;
   localparam logic [2:0] ST_ERROR = 3'd6;

   localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

   logic [2:0]            state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [31:0]           asm_q, asm_d;
   logic [7:0]            csum_q, csum_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  core_rst_n_q, core_rst_n_d;
   logic                  load_done_q, load_done_d;
   logic                  load_err_q, load_err_d;

   logic                  fire;
   logic                  is_magic;
   logic [15:0]           len_full;
   logic [31:0]           word_shift;
   logic                  in_frame;

   assign rx_ready   = 1'b1;
   assign fire       = rx_valid;
   assign is_magic   = (rx_data == MAGIC);
   assign len_full   = {rx_data, len_q[7:0]};
   // Bytes arrive LSB first, so shift in from the top: after four bytes
   // byte 0 sits in bits 7:0.
   assign word_shift = {rx_data, asm_q[31:8]};
   assign in_frame   = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      csum_d       = csum_q;
      timer_d      = timer_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      core_rst_n_d = core_rst_n_q;
      load_done_d  = load_done_q;
      load_err_d   = load_err_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            // Frame start: clear status, hold the core in reset again.
            if (fire && is_magic) begin
               state_d      = ST_LEN0;
               csum_d       = 8'h00;
               timer_d      = '0;
               word_cnt_d   = '0;
               byte_idx_d   = 2'd0;
               load_done_d  = 1'b0;
               load_err_d   = 1'b0;
               core_rst_n_d = 1'b0;
            end
         end
         ST_LEN0: begin
            if (fire) begin
               len_d[7:0] = rx_data;
               state_d    = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (fire) begin
               len_d      = len_full;
               word_cnt_d = '0;
               byte_idx_d = 2'd0;
               // Rejecting oversize images here is what keeps the word
               // counter from ever wrapping.
               if ({16'h0000, len_full} > CAPACITY) begin
                  state_d    = ST_ERROR;
                  load_err_d = 1'b1;
               end else if (len_full == 16'h0000) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (fire) begin
               asm_d      = word_shift;
               csum_d     = csum_q + rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                  imem_wdata_d = word_shift;
                  word_cnt_d   = word_cnt_q + 1'b1;
                  if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) begin
                     state_d = ST_CSUM;
                  end
               end
            end
         end
         ST_CSUM: begin
            if (fire) begin
               if (rx_data == csum_q) begin
                  state_d      = ST_DONE;
                  load_done_d  = 1'b1;
                  core_rst_n_d = 1'b1;
               end else begin
                  state_d    = ST_ERROR;
                  load_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Inter-byte idle timer inside a frame. Only idle cycles reach the
      // abort path, so a partial word is never written.
      if (in_frame) begin
         if (fire) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + 1'b1;
            if (timer_q + 1'b1 == TO_MAX) begin
               state_d      = ST_ERROR;
               load_err_d   = 1'b1;
               core_rst_n_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_idx_q   <= 2'd0;
         asm_q        <= '0;
         csum_q       <= 8'h00;
         timer_q      <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_n_q <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_idx_q   <= byte_idx_d;
         asm_q        <= asm_d;
         csum_q       <= csum_d;
         timer_q      <= timer_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_rst_n_q <= core_rst_n_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- directed bench for prog_loader (ADDR_WIDTH=2,
// TIMEOUT_CYCLES=16). Expected imem writes are queued as payload is driven
// and popped by a monitor on every imem_we pulse.
module tb_prog_loader;

   localparam int AW = 2;

   logic          clk;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          load_done;
   logic          load_err;

   int checks;
   int failures;
   int gap_max;

   logic [AW+31:0] exp_q[$];

   prog_loader #(
      .ADDR_WIDTH     (AW),
      .MAGIC          (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_we"},    64'(imem_we),    64'd0);
      check({tag, "_addr"},  64'(imem_addr),  64'd0);
      check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
      check({tag, "_crst"},  64'(core_rst_n), 64'd0);
      check({tag, "_done"},  64'(load_done),  64'd0);
      check({tag, "_err"},   64'(load_err),   64'd0);
      check({tag, "_ready"}, 64'(rx_ready),   64'd1);
   endtask

   // scoreboard: every write strobe must match the head of the queue
   always @(negedge clk) begin
      if (!rst && imem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 64'({imem_addr, imem_wdata}), 64'h0);
            checks = checks;
         end else begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            check("write", 64'({imem_addr, imem_wdata}), 64'(e));
         end
      end
   end

   initial begin
      logic [7:0]  b;
      logic [7:0]  sum;
      logic [31:0] w;
      checks   = 0;
      failures = 0;
      gap_max  = 3;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // nominal 2-word load
      expect_write(2'd0, 32'h00000013);
      expect_write(2'd1, 32'h0000006F);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("nom_crst_pre", 64'(core_rst_n), 64'd0);
      send_byte(8'h82);
      check("nom_done", 64'(load_done), 64'd1);
      check("nom_crst", 64'(core_rst_n), 64'd1);
      check("nom_err", 64'(load_err), 64'd0);
      check("nom_q", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      check("nom_hold", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b0, 2'd1, 32'h0000006F}));

      // bad checksum after a restart from DONE
      expect_write(2'd0, 32'h00000013);
      expect_write(2'd1, 32'h0000006F);
      send_byte(8'hA5);
      check("bad_restart_done", 64'(load_done), 64'd0);
      check("bad_restart_crst", 64'(core_rst_n), 64'd0);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h83);
      check("bad_err", 64'(load_err), 64'd1);
      check("bad_done", 64'(load_done), 64'd0);
      check("bad_crst", 64'(core_rst_n), 64'd0);
      check("bad_q", 64'(exp_q.size()), 64'd0);

      // garbage bytes ignored in ERROR, then zero-length frame
      send_byte(8'h00); send_byte(8'hFF);
      check("garb_err_sticky", 64'(load_err), 64'd1);
      send_byte(8'hA5);
      check("garb_err_clear", 64'(load_err), 64'd0);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("zero_done", 64'(load_done), 64'd1);
      check("zero_crst", 64'(core_rst_n), 64'd1);

      // oversize length (5 > 4 words), then restart with a 1-word image
      send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
      check("over_err", 64'(load_err), 64'd1);
      check("over_done", 64'(load_done), 64'd0);
      send_byte(8'h01); send_byte(8'h02);
      check("over_ignore", 64'(load_err), 64'd1);
      expect_write(2'd0, 32'h04030201);
      send_byte(8'hA5);
      check("restart_err_clear", 64'(load_err), 64'd0);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h0A);
      check("restart_done", 64'(load_done), 64'd1);
      check("restart_q", 64'(exp_q.size()), 64'd0);

      // full-capacity image (N = 4), back-to-back bytes, random payload
      gap_max = 0;
      sum = 8'h00;
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
      for (int i = 0; i < 4; i++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            b = 8'($urandom_range(0, 255));
            w[j*8 +: 8] = b;
            sum = sum + b;
            if (j == 3) expect_write(AW'(i), w);
            send_byte(b);
         end
      end
      send_byte(sum);
      check("full_done", 64'(load_done), 64'd1);
      check("full_q", 64'(exp_q.size()), 64'd0);
      gap_max = 3;

      // inter-byte timeout with a partial word pending
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      gap_max = 0;
      send_byte(8'h11); send_byte(8'h22);
      repeat (15) @(negedge clk);
      check("to_not_yet", 64'(load_err), 64'd0);
      @(negedge clk);
      check("to_err", 64'(load_err), 64'd1);
      check("to_crst", 64'(core_rst_n), 64'd0);
      repeat (4) @(negedge clk);
      check("to_q", 64'(exp_q.size()), 64'd0);
      gap_max = 3;

      // reset in the middle of a frame
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_state", 64'({imem_we, core_rst_n, load_done, load_err}), 64'h0);
      rst = 1'b0;
      expect_write(2'd0, 32'h40302010);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
      send_byte(8'hA0);
      check("mid_done", 64'(load_done), 64'd1);
      check("mid_crst", 64'(core_rst_n), 64'd1);
      check("mid_q", 64'(exp_q.size()), 64'd0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader that sits directly upstream of the pipelined core top level. It receives a framed program image from a byte source (UART RX), assembles little-endian 32-bit words and writes them into the core's instruction memory write port. It holds the core in reset until the image is fully written and its checksum verified. This replaces hex-file preload for on-board bring-up.

Parameters:
ADDR_WIDTH, 12, instruction memory word-address width; capacity is 2**ADDR_WIDTH words.
MAGIC, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  ADDR_WIDTH  word address of the write
imem_wdata  out  32  word to write
core_rst_n  out  1  active-low reset to the core; 0 while loading
load_done  out  1  image loaded and checksum correct (sticky until next frame or rst)
load_err  out  1  frame aborted (sticky until next frame or rst)

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. Outputs: imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, load_done=0, load_err=0, rx_ready=1. Internal count, byte index, checksum and timer are cleared. A reset mid-frame aborts the frame without further writes.
- Frame format: MAGIC, LEN_LO, LEN_HI (word count N, 16-bit little-endian), 4*N payload bytes (each word little-endian, byte 0 = bits 7:0), CSUM. CSUM = 8-bit modular sum of all 4*N payload bytes.
- rx_ready is 1 in every state. The loader never stalls the source.
- States:
  - IDLE: a byte equal to MAGIC -> LEN0. Any other byte is discarded and the state stays IDLE.
  - LEN0: store LEN_LO -> LEN1.
  - LEN1: store LEN_HI. If N > 2**ADDR_WIDTH -> ERROR. If N == 0 -> CSUM. Otherwise -> DATA with word counter=0 and byte index=0.
  - DATA: shift each byte into a word assembly register and add it to the checksum. On the 4th byte of a word, the next cycle drives imem_we=1, imem_addr=word counter and imem_wdata=assembled word. imem_we is high for exactly one cycle. After the Nth word is written -> CSUM.
  - CSUM: received byte == checksum -> DONE; otherwise -> ERROR.
  - DONE: load_done=1, core_rst_n=1, both asserted the cycle after the CSUM byte is accepted.
  - ERROR: load_err=1, core_rst_n=0.
- Restart: in DONE or ERROR, a MAGIC byte -> LEN0. In the same transition core_rst_n=0, load_done=0 and load_err=0 (effective the next cycle). Non-MAGIC bytes are ignored. In IDLE, a MAGIC byte also clears load_done and load_err.
- Timeout: in LEN0, LEN1, DATA and CSUM, a timer counts cycles with no accepted byte and resets on each accepted byte. When it reaches TIMEOUT_CYCLES -> ERROR. No partial word is written.
- Addressing: imem_addr is the word counter, starting at 0 for every frame. The counter never wraps, because of the length check in LEN1.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Back-to-back bytes (rx_valid high on every cycle) are fully supported. Write throughput is one word per 4 cycles.

Test Plan:
- Nominal load: after rst, send A5 02 00 13 00 00 00 6F 00 00 00 then CSUM 0x82 -> imem_we pulses twice: (addr 0, 0x00000013), then (addr 1, 0x0000006F). load_done=1 and core_rst_n=1 one cycle after CSUM.
- Bad checksum: same frame with CSUM 0x83 -> both words are written, then load_err=1, core_rst_n stays 0, load_done=0.
- Garbage and zero length: send 00 FF then A5 00 00 00 -> the leading bytes are ignored, no imem_we pulses, load_done=1.
- Oversize and restart: with ADDR_WIDTH=2, send A5 05 00 -> load_err=1 after LEN_HI. Then A5 01 00 01 02 03 04 0A -> load_err clears, word 0x04030201 is written to addr 0, load_done=1.
- Timeout: with TIMEOUT_CYCLES=16, send A5 01 00 11 22 then idle 16 cycles -> load_err=1, no imem_we pulse.
- Reset mid-frame: assert rst after 2 payload bytes, then send a full valid 1-word frame -> no write from the aborted frame, correct write at addr 0, load_done=1.
